// File: rtl/type1_dmmrx_mchn.sv
// TYPE1 RX data-memory manager: N-channel frame buffer with per-channel ready flags and lengths.
// Optional even-parity protection of stored words is enabled by defining TYPE1_DMMRX_PARITY_EN.
module type1_dmmrx_mchn #(
  parameter int         DATA_W    = 18,
  parameter int         CHN_NUM   = 16,
  parameter int         CHN_DEPTH = 64,
  parameter int         OFS_W     = 6,
  parameter logic [1:0] EX_NUM    = 2'b00,
  parameter logic [3:0] MPU_SLOT  = 4'd0
) (
  input  logic               clk_100m,
  input  logic               rst_100m,
  input  logic [1:0]         ex_box_num,
  input  logic               wr_en,
  input  logic [3:0]         wr_chn,
  input  logic [OFS_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_last,
  input  logic               rr_sel,
  input  logic               rd_sel,
  input  logic [6:0]         rd_port,
  input  logic [OFS_W-1:0]   rd_addr,
  input  logic               rd_done,
  output logic               rd_port_sel,
  output logic [DATA_W-1:0]  rd_data,
  output logic [OFS_W:0]     rd_len,
  output logic [CHN_NUM-1:0] chn_vld,
  output logic               wr_err,
`ifdef TYPE1_DMMRX_PARITY_EN
  output logic               rd_par_err,
`endif
  output logic               rd_err
);

  localparam int CHN_W  = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;
  localparam int ADDR_W = CHN_W + OFS_W;
`ifdef TYPE1_DMMRX_PARITY_EN
  localparam int RAM_W  = DATA_W + 1;
`else
  localparam int RAM_W  = DATA_W;
`endif
  localparam logic [OFS_W:0] DEPTH_L  = (OFS_W+1)'(CHN_DEPTH);
  localparam logic [3:0]     MPU_CODE = MPU_SLOT + 4'd2;
  localparam logic [4:0]     CHN_LIM  = 5'(CHN_NUM);

  // Stage T: write acceptance and read-port decode
  logic             wr_box_hit, wr_chn_ok, wr_acc, wr_drop;
  logic             rd_box_hit, mpu_hit, ex_req, ex_chn_ok;
  logic             rd_hit_d, rd_bad_d;
  logic [3:0]       rd_chn_d;
  logic [RAM_W-1:0] wr_word;
  logic [OFS_W:0]   cnt_cur, cnt_inc_d;

  assign wr_box_hit = (ex_box_num == EX_NUM);
  assign wr_chn_ok  = ({1'b0, wr_chn} < CHN_LIM);
  assign wr_acc     = wr_en & wr_box_hit & wr_chn_ok;
  assign wr_drop    = wr_en & wr_box_hit & ~wr_chn_ok;

  assign rd_box_hit = (rd_port[5:4] == EX_NUM);
  assign mpu_hit    = rd_sel & ~rd_port[6] & rd_box_hit & (rd_port[3:0] == MPU_CODE);
  assign ex_req     = rd_sel & rd_port[6] & rd_box_hit & rr_sel;
  assign ex_chn_ok  = ({1'b0, rd_port[3:0]} < CHN_LIM);
  assign rd_hit_d   = mpu_hit | (ex_req & ex_chn_ok);
  assign rd_bad_d   = ex_req & ~ex_chn_ok;
  assign rd_chn_d   = mpu_hit ? 4'd0 : rd_port[3:0];

`ifdef TYPE1_DMMRX_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
`endif

  // Per-channel beat counters and captured lengths, packed so reset clears them in one step
  logic [CHN_NUM-1:0][OFS_W:0] cnt_q, len_q;
  logic [CHN_NUM-1:0]          vld_q;

  assign cnt_cur   = cnt_q[wr_chn[CHN_W-1:0]];
  assign cnt_inc_d = (cnt_cur >= DEPTH_L) ? DEPTH_L : cnt_cur + 1'b1;

  // Stage T -> T+1: RAM read is registered at the same edge as the write, so a
  // colliding read sees the word that was stored before this write.
  logic [RAM_W-1:0] ram_q [0:(2**ADDR_W)-1];
  logic [RAM_W-1:0] ram_dout_p1;

  always_ff @(posedge clk_100m) begin
    if (wr_acc)
      ram_q[{wr_chn[CHN_W-1:0], wr_addr}] <= wr_word;
    ram_dout_p1 <= ram_q[{rd_chn_d[CHN_W-1:0], rd_addr}];
  end

  logic             sel_p1_q, sel_p2_q;
  logic [CHN_W-1:0] chn_p1_q, last_chn_q;
  logic [DATA_W-1:0] rd_data_p2_q;
  logic [OFS_W:0]   rd_len_p2_q;
  logic             wr_err_q, rd_err_q;
`ifdef TYPE1_DMMRX_PARITY_EN
  logic             par_err_p2_q;
`endif

  always_ff @(posedge clk_100m or negedge rst_100m) begin
    if (!rst_100m) begin
      sel_p1_q     <= 1'b0;
      chn_p1_q     <= '0;
      sel_p2_q     <= 1'b0;
      rd_data_p2_q <= '0;
      rd_len_p2_q  <= '0;
      last_chn_q   <= '0;
      wr_err_q     <= 1'b0;
      rd_err_q     <= 1'b0;
      cnt_q        <= '0;
      len_q        <= '0;
      vld_q        <= '0;
`ifdef TYPE1_DMMRX_PARITY_EN
      par_err_p2_q <= 1'b0;
`endif
    end else begin
      sel_p1_q <= rd_hit_d;
      chn_p1_q <= rd_chn_d[CHN_W-1:0];
      wr_err_q <= wr_drop;
      rd_err_q <= rd_bad_d;
      if (rd_hit_d)
        last_chn_q <= rd_chn_d[CHN_W-1:0];

      // Stage T+1 -> T+2: present data and length of the selected channel
      sel_p2_q     <= sel_p1_q;
      rd_data_p2_q <= sel_p1_q ? ram_dout_p1[DATA_W-1:0] : '0;
      rd_len_p2_q  <= sel_p1_q ? len_q[chn_p1_q] : '0;
`ifdef TYPE1_DMMRX_PARITY_EN
      par_err_p2_q <= sel_p1_q & (^ram_dout_p1);
`endif

      // Clear comes first so a frame completing in the same cycle wins
      if (rd_done)
        vld_q[last_chn_q] <= 1'b0;
      if (wr_acc) begin
        for (int c = 0; c < CHN_NUM; c++) begin
          if (wr_chn == 4'(c)) begin
            if (wr_last) begin
              len_q[c] <= cnt_inc_d;
              cnt_q[c] <= '0;
              vld_q[c] <= 1'b1;
            end else begin
              cnt_q[c] <= cnt_inc_d;
            end
          end
        end
      end
    end
  end

  assign rd_port_sel = sel_p2_q;
  assign rd_data     = rd_data_p2_q;
  assign rd_len      = rd_len_p2_q;
  assign chn_vld     = vld_q;
  assign wr_err      = wr_err_q;
  assign rd_err      = rd_err_q;
`ifdef TYPE1_DMMRX_PARITY_EN
  assign rd_par_err  = par_err_p2_q;
`endif

endmodule

// File: tb/tb_type1_dmmrx_mchn.sv
// Directed bench for type1_dmmrx_mchn (8 channels, box 1, MPU slot 3 -> code 5).
// The TYPE1_DMMRX_PARITY_EN build adds a stored-parity corruption check.
module tb_type1_dmmrx_mchn;
  localparam int         DATA_W    = 18;
  localparam int         CHN_NUM   = 8;
  localparam int         CHN_DEPTH = 64;
  localparam int         OFS_W     = 6;
  localparam logic [1:0] EX_NUM    = 2'b01;
  localparam logic [3:0] MPU_SLOT  = 4'd3;

  logic               clk_100m = 1'b0;
  logic               rst_100m = 1'b0;
  logic [1:0]         ex_box_num = '0;
  logic               wr_en = 1'b0;
  logic [3:0]         wr_chn = '0;
  logic [OFS_W-1:0]   wr_addr = '0;
  logic [DATA_W-1:0]  wr_data = '0;
  logic               wr_last = 1'b0;
  logic               rr_sel = 1'b0;
  logic               rd_sel = 1'b0;
  logic [6:0]         rd_port = '0;
  logic [OFS_W-1:0]   rd_addr = '0;
  logic               rd_done = 1'b0;
  logic               rd_port_sel;
  logic [DATA_W-1:0]  rd_data;
  logic [OFS_W:0]     rd_len;
  logic [CHN_NUM-1:0] chn_vld;
  logic               wr_err;
  logic               rd_err;
`ifdef TYPE1_DMMRX_PARITY_EN
  logic               rd_par_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  type1_dmmrx_mchn #(
    .DATA_W(DATA_W), .CHN_NUM(CHN_NUM), .CHN_DEPTH(CHN_DEPTH), .OFS_W(OFS_W),
    .EX_NUM(EX_NUM), .MPU_SLOT(MPU_SLOT)
  ) dut (
    .clk_100m(clk_100m), .rst_100m(rst_100m), .ex_box_num(ex_box_num),
    .wr_en(wr_en), .wr_chn(wr_chn), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_last(wr_last), .rr_sel(rr_sel), .rd_sel(rd_sel), .rd_port(rd_port),
    .rd_addr(rd_addr), .rd_done(rd_done), .rd_port_sel(rd_port_sel),
    .rd_data(rd_data), .rd_len(rd_len), .chn_vld(chn_vld), .wr_err(wr_err),
`ifdef TYPE1_DMMRX_PARITY_EN
    .rd_par_err(rd_par_err),
`endif
    .rd_err(rd_err)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_beat(input logic [1:0] box, input logic [3:0] chn, input int ofs,
                         input logic [DATA_W-1:0] d, input logic last);
    ex_box_num = box; wr_en = 1'b1; wr_chn = chn; wr_addr = OFS_W'(ofs);
    wr_data = d; wr_last = last;
    tick();
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic set_rd(input logic [6:0] port, input logic rr, input int ofs);
    rd_sel = 1'b1; rd_port = port; rr_sel = rr; rd_addr = OFS_W'(ofs);
  endtask

  task automatic clr_rd();
    rd_sel = 1'b0; rr_sel = 1'b0; rd_port = '0;
  endtask

  // Issue one read, return to idle, and sample the T+2 outputs
  task automatic rd_one(input logic [6:0] port, input logic rr, input int ofs);
    set_rd(port, rr, ofs);
    tick();
    clr_rd();
    tick();
  endtask

  initial begin
    // Reset held from time 0
    repeat (2) tick();
    chk("rst_sel",  32'(rd_port_sel), 32'd0);
    chk("rst_data", 32'(rd_data),     32'd0);
    chk("rst_len",  32'(rd_len),      32'd0);
    chk("rst_vld",  32'(chn_vld),     32'd0);
    chk("rst_errs", {30'd0, wr_err, rd_err}, 32'd0);
    rst_100m = 1'b1;
    tick();

    // Frame of 10 beats into channel 3
    for (int i = 0; i < 10; i++)
      wr_beat(EX_NUM, 4'd3, i, DATA_W'(32'h100 + i), (i == 9));
    chk("vld_after_frame3", 32'(chn_vld), 32'h08);

    set_rd({1'b1, EX_NUM, 4'd3}, 1'b1, 5);
    tick();
    clr_rd();
    chk("ex_rd_t1_sel", 32'(rd_port_sel), 32'd0);
    tick();
    chk("ex_rd_sel",  32'(rd_port_sel), 32'd1);
    chk("ex_rd_data", 32'(rd_data),     32'h105);
    chk("ex_rd_len",  32'(rd_len),      32'd10);
    tick();
    chk("ex_rd_idle_sel",  32'(rd_port_sel), 32'd0);
    chk("ex_rd_idle_data", 32'(rd_data),     32'd0);

    // Beat tagged for another box must not land
    wr_beat(2'b10, 4'd3, 5, 18'h3FFFF, 1'b0);
    rd_one({1'b1, EX_NUM, 4'd3}, 1'b1, 5);
    chk("other_box_wr_ignored", 32'(rd_data), 32'h105);

    // MPU read maps onto channel 0
    wr_beat(EX_NUM, 4'd0, 0, 18'h2AA, 1'b1);
    chk("vld_after_chn0", 32'(chn_vld), 32'h09);
    rd_one({1'b0, EX_NUM, MPU_SLOT + 4'd2}, 1'b0, 0);
    chk("mpu_rd_sel",  32'(rd_port_sel), 32'd1);
    chk("mpu_rd_data", 32'(rd_data),     32'h2AA);
    chk("mpu_rd_len",  32'(rd_len),      32'd1);
    rd_one({1'b0, EX_NUM, MPU_SLOT}, 1'b0, 0);
    chk("mpu_wrong_slot_sel", 32'(rd_port_sel), 32'd0);
    rd_one({1'b1, 2'b10, 4'd3}, 1'b1, 5);
    chk("ex_wrong_box_sel",  32'(rd_port_sel), 32'd0);
    chk("ex_wrong_box_data", 32'(rd_data),     32'd0);
    rd_one({1'b1, EX_NUM, 4'd3}, 1'b0, 5);
    chk("ex_no_grant_sel", 32'(rd_port_sel), 32'd0);

    // Read and write of the same word in one cycle
    wr_beat(EX_NUM, 4'd1, 7, 18'h011, 1'b0);
    ex_box_num = EX_NUM; wr_en = 1'b1; wr_chn = 4'd1; wr_addr = 6'd7; wr_data = 18'h022;
    set_rd({1'b1, EX_NUM, 4'd1}, 1'b1, 7);
    tick();
    wr_en = 1'b0;
    clr_rd();
    tick();
    chk("rbw_old_data", 32'(rd_data), 32'h011);
    chk("rbw_len_uncaptured", 32'(rd_len), 32'd0);
    rd_one({1'b1, EX_NUM, 4'd1}, 1'b1, 7);
    chk("rbw_new_data", 32'(rd_data), 32'h022);

    // Back-to-back reads of channel 3 offsets 0,1,2
    set_rd({1'b1, EX_NUM, 4'd3}, 1'b1, 0);
    tick();
    rd_addr = 6'd1;
    tick();
    chk("b2b_0", 32'(rd_data), 32'h100);
    rd_addr = 6'd2;
    tick();
    chk("b2b_1", 32'(rd_data), 32'h101);
    clr_rd();
    tick();
    chk("b2b_2", 32'(rd_data), 32'h102);
    chk("b2b_sel", 32'(rd_port_sel), 32'd1);

    // Out-of-range channels: dropped write and rejected read
    wr_beat(EX_NUM, 4'd7, 0, 18'h777, 1'b0);
    ex_box_num = EX_NUM; wr_en = 1'b1; wr_chn = 4'd15; wr_addr = 6'd0;
    wr_data = 18'h1234; wr_last = 1'b1;
    tick();
    wr_en = 1'b0; wr_last = 1'b0;
    chk("wr_err_pulse", 32'(wr_err), 32'd1);
    chk("wr_err_vld_unchanged", 32'(chn_vld), 32'h09);
    tick();
    chk("wr_err_clears", 32'(wr_err), 32'd0);
    rd_one({1'b1, EX_NUM, 4'd7}, 1'b1, 0);
    chk("wr_err_ram_unchanged", 32'(rd_data), 32'h777);
    set_rd({1'b1, EX_NUM, 4'd12}, 1'b1, 0);
    tick();
    clr_rd();
    chk("rd_err_pulse", 32'(rd_err), 32'd1);
    tick();
    chk("rd_err_clears", 32'(rd_err), 32'd0);
    chk("rd_err_no_sel", 32'(rd_port_sel), 32'd0);

    // Frame-ready flag: clear by rd_done, then set and clear together
    wr_beat(EX_NUM, 4'd2, 0, 18'h0AB, 1'b1);
    chk("vld_chn2_set", 32'(chn_vld), 32'h0D);
    rd_one({1'b1, EX_NUM, 4'd2}, 1'b1, 0);
    chk("chn2_rd_data", 32'(rd_data), 32'h0AB);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("rd_done_clears_chn2", 32'(chn_vld), 32'h09);
    rd_done = 1'b1;
    wr_beat(EX_NUM, 4'd2, 0, 18'h0CD, 1'b1);
    rd_done = 1'b0;
    chk("set_wins_over_clear", 32'(chn_vld), 32'h0D);

`ifdef TYPE1_DMMRX_PARITY_EN
    rd_one({1'b1, EX_NUM, 4'd2}, 1'b1, 0);
    chk("par_ok", 32'(rd_par_err), 32'd0);
    dut.ram_q[{3'd2, 6'd0}][0] = ~dut.ram_q[{3'd2, 6'd0}][0];
    rd_one({1'b1, EX_NUM, 4'd2}, 1'b1, 0);
    chk("par_err_flag", 32'(rd_par_err), 32'd1);
    chk("par_err_sel",  32'(rd_port_sel), 32'd1);
`endif

    // Asynchronous reset while a read result is on the outputs
    set_rd({1'b1, EX_NUM, 4'd3}, 1'b1, 5);
    tick();
    clr_rd();
    tick();
    chk("pre_rst_sel", 32'(rd_port_sel), 32'd1);
    #1;
    rst_100m = 1'b0;
    #1;
    chk("async_rst_sel",  32'(rd_port_sel), 32'd0);
    chk("async_rst_data", 32'(rd_data),     32'd0);
    chk("async_rst_len",  32'(rd_len),      32'd0);
    chk("async_rst_vld",  32'(chn_vld),     32'd0);
    #1;
    rst_100m = 1'b1;
    tick();
    chk("post_rst_sel", 32'(rd_port_sel), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
